// File: rtl/mlp_pkg.sv
// Shared definitions for the time-multiplexed event-denoising MLP (mlp_seq).
// Holds the FC1/FC2 accumulator width helpers, the sequencer state encoding
// and the weight-bank select encoding used on the write port.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FC1   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // wr_sel encodings
  localparam logic FC1_BANK = 1'b0;
  localparam logic FC2_BANK = 1'b1;

  // FC1 dot-product width: signed (W_X+1)-bit input times W_K-bit weight,
  // summed over n_in taps, with one spare bit.
  function automatic int fc1_sum_width(input int w_x, input int w_k, input int n_in);
    return w_x + w_k + 2 + $clog2(n_in);
  endfunction

  // FC2 accumulator width: W_X-bit activation times W_K-bit weight over n2 neurons.
  function automatic int fc2_sum_width(input int w_x, input int w_k, input int n2);
    return w_x + w_k + 2 + $clog2(n2);
  endfunction

endpackage

// File: rtl/mlp_seq_if.sv
// Handshake and weight-load bus for mlp_seq.
// master: patch builder / loader side (drives input vector, m_ready, weight writes).
// slave : mlp_seq side (drives s_ready, m_valid, out).
interface mlp_seq_if #(
  parameter int N_IN   = 49,
  parameter int W_X    = 4,
  parameter int W_K    = 4,
  parameter int W_Y    = 16,
  parameter int W_ADDR = 9
);
  logic                   s_valid;
  logic                   s_ready;
  logic [N_IN*W_X-1:0]    in_mag;
  logic [N_IN-1:0]        in_pol;
  logic                   m_valid;
  logic                   m_ready;
  logic [W_Y-1:0]         out;
  logic                   wr_en;
  logic                   wr_sel;
  logic [W_ADDR-1:0]      wr_addr;
  logic [W_K-1:0]         wr_data;

  modport master (
    output s_valid, in_mag, in_pol, m_ready, wr_en, wr_sel, wr_addr, wr_data,
    input  s_ready, m_valid, out
  );

  modport slave (
    input  s_valid, in_mag, in_pol, m_ready, wr_en, wr_sel, wr_addr, wr_data,
    output s_ready, m_valid, out
  );
endinterface

// File: rtl/mlp_dot.sv
// Purpose: signed dot product of N_IN sign-magnitude inputs with one weight row.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: i_mag (N_IN x W_X magnitudes), i_pol (1 = +mag), i_k (N_IN x W_K signed
//        weights), o_sum (W_A-bit signed sum).
module mlp_dot #(
  parameter int N_IN = 49,
  parameter int W_X  = 4,
  parameter int W_K  = 4,
  parameter int W_A  = 16
) (
  input  logic [N_IN*W_X-1:0]   i_mag,
  input  logic [N_IN-1:0]       i_pol,
  input  logic [N_IN*W_K-1:0]   i_k,
  output logic signed [W_A-1:0] o_sum
);

  localparam int W_I = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic signed [W_X+W_K:0] w_prod [N_IN];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_tap
    logic signed [W_X:0] w_x;
    // -mag always fits: magnitude is at most 2^W_X-1.
    assign w_x = i_pol[gi] ?  $signed({1'b0, i_mag[gi*W_X +: W_X]})
                           : -$signed({1'b0, i_mag[gi*W_X +: W_X]});
    assign w_prod[gi] = w_x * $signed(i_k[gi*W_K +: W_K]);
  end

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      o_sum = o_sum + W_A'(w_prod[W_I'(i)]);
    end
  end

endmodule

// File: rtl/mlp_seq.sv
// Purpose: time-multiplexed 2-layer MLP; one FC1 neuron per cycle, FC2 accumulated one cycle behind.
// Latency: N2+2 cycles from input handshake to m_valid; one vector in flight at a time.
// Backpressure: s_ready only in IDLE; result held stable in DONE until m_ready.
// Ports: clk, rstn (async active-low); bus (mlp_seq_if.slave) carries s_valid/s_ready,
//        in_mag/in_pol, m_valid/m_ready/out and the wr_en/wr_sel/wr_addr/wr_data weight port.
// Build option: MLP_OUT_SAT_EN saturates the result to W_Y bits instead of wrapping.
module mlp_seq
  import mlp_pkg::*;
#(
  parameter int N1     = 98,
  parameter int N2     = 10,
  parameter int W_X    = 4,
  parameter int W_K    = 4,
  parameter int W_Y    = 16,
  parameter int SHIFT1 = 4
) (
  input logic       clk,
  input logic       rstn,
  mlp_seq_if.slave  bus
);

  localparam int N_IN   = N1 / 2;
  localparam int N_K1   = N2 * N_IN;
  localparam int W_ADDR = $clog2(N_K1);
  localparam int W_J    = (N2 > 1) ? $clog2(N2) : 1;
  localparam int W_A1   = fc1_sum_width(W_X, W_K, N_IN);
  localparam int W_A2   = fc2_sum_width(W_X, W_K, N2);

  localparam logic signed [W_A1-1:0] H_MAX = W_A1'((1 << W_X) - 1);

  state_e                  r_state;
  logic                    r_s_ready;
  logic                    r_m_valid;
  logic [W_Y-1:0]          r_out;
  logic [W_J-1:0]          r_j;
  logic [N_IN*W_X-1:0]     r_mag;
  logic [N_IN-1:0]         r_pol;
  logic [W_X-1:0]          r_h;
  logic                    r_h_vld;
  logic [W_J-1:0]          r_hj;
  logic signed [W_A2-1:0]  r_acc;
  logic signed [W_K-1:0]   r_k1 [N_K1];
  logic signed [W_K-1:0]   r_k2 [N2];

  logic [W_ADDR-1:0]       w_base;
  logic [N_IN*W_K-1:0]     w_row;
  logic signed [W_A1-1:0]  w_a1;
  logic signed [W_A1-1:0]  w_a1_sh;
  logic [W_X-1:0]          w_h;
  logic signed [W_X+W_K:0] w_p2;
  logic signed [W_A2-1:0]  w_acc_nxt;
  logic [W_Y-1:0]          w_out_nxt;
  logic                    w_wr_ok;

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.out     = r_out;

  // ---------------- FC1: row j of the weight file against the latched vector
  assign w_base = W_ADDR'(N_IN) * W_ADDR'(r_j);

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_row
    assign w_row[gi*W_K +: W_K] = r_k1[w_base + W_ADDR'(gi)];
  end

  mlp_dot #(
    .N_IN (N_IN),
    .W_X  (W_X),
    .W_K  (W_K),
    .W_A  (W_A1)
  ) u_dot (
    .i_mag (r_mag),
    .i_pol (r_pol),
    .i_k   (w_row),
    .o_sum (w_a1)
  );

  // ReLU + requantise into the W_X-bit activation range.
  always_comb begin
    w_a1_sh = w_a1 >>> SHIFT1;
    if (w_a1_sh[W_A1-1])       w_h = '0;
    else if (w_a1_sh > H_MAX)  w_h = '1;
    else                       w_h = w_a1_sh[W_X-1:0];
  end

  // ---------------- FC2: accumulate the activation registered last cycle
  assign w_p2      = $signed({1'b0, r_h}) * r_k2[r_hj];
  assign w_acc_nxt = r_h_vld ? (r_acc + W_A2'(w_p2)) : r_acc;

`ifdef MLP_OUT_SAT_EN
  if (W_Y < W_A2) begin : g_out_sat
    localparam logic signed [W_A2-1:0] O_MAX = W_A2'((1 << (W_Y - 1)) - 1);
    localparam logic signed [W_A2-1:0] O_MIN = W_A2'(-(1 << (W_Y - 1)));
    always_comb begin
      if (w_acc_nxt > O_MAX)       w_out_nxt = W_Y'(O_MAX);
      else if (w_acc_nxt < O_MIN)  w_out_nxt = W_Y'(O_MIN);
      else                         w_out_nxt = W_Y'(w_acc_nxt);
    end
  end else begin : g_out_ext
    assign w_out_nxt = W_Y'(w_acc_nxt);
  end
`else
  // Truncates (wraps) when W_Y is narrower, sign-extends when wider.
  assign w_out_nxt = W_Y'(w_acc_nxt);
`endif

  // ---------------- Sequencer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_out     <= '0;
      r_j       <= '0;
      r_mag     <= '0;
      r_pol     <= '0;
      r_h       <= '0;
      r_h_vld   <= 1'b0;
      r_hj      <= '0;
      r_acc     <= '0;
    end else begin
      r_h_vld <= 1'b0;
      r_acc   <= w_acc_nxt;
      case (r_state)
        IDLE: begin
          if (bus.s_valid && r_s_ready) begin
            r_mag     <= bus.in_mag;
            r_pol     <= bus.in_pol;
            r_acc     <= '0;
            r_j       <= '0;
            r_s_ready <= 1'b0;
            r_state   <= FC1;
          end
        end
        FC1: begin
          r_h     <= w_h;
          r_hj    <= r_j;
          r_h_vld <= 1'b1;
          if (r_j == W_J'(N2 - 1)) r_state <= DRAIN;
          else                     r_j     <= r_j + 1'b1;
        end
        DRAIN: begin
          // w_acc_nxt already includes the last neuron's contribution.
          r_out     <= w_out_nxt;
          r_m_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---------------- Weight register file; writes land only while IDLE.
  // A write coinciding with the input handshake lands at that edge, so FC1
  // (which starts reading the next cycle) already sees it.
  assign w_wr_ok = bus.wr_en && (r_state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < N_K1; n++) r_k1[W_ADDR'(n)] <= '0;
      for (int n = 0; n < N2; n++)   r_k2[W_J'(n)]    <= '0;
    end else if (w_wr_ok) begin
      if (bus.wr_sel == FC1_BANK) begin
        if ({1'b0, bus.wr_addr} < (W_ADDR + 1)'(N_K1)) r_k1[bus.wr_addr] <= bus.wr_data;
      end else if (bus.wr_sel == FC2_BANK) begin
        if (bus.wr_addr < W_ADDR'(N2)) r_k2[bus.wr_addr[W_J-1:0]] <= bus.wr_data;
      end
    end
  end

endmodule

// File: tb/tb_mlp_seq.sv
// Bench for mlp_seq (W_Y = 8 so both the wrapping and saturating output paths
// are exercised by the 7/7/15 vector). A reference model over shadow weight
// arrays computes each expected score when the vector is sent; results are
// popped from the scoreboard queue when the DUT presents them.
module tb_mlp_seq;
  import mlp_pkg::*;

  localparam int N1     = 98;
  localparam int N_IN   = N1 / 2;
  localparam int N2     = 10;
  localparam int W_X    = 4;
  localparam int W_K    = 4;
  localparam int W_Y    = 8;
  localparam int SHIFT1 = 4;
  localparam int W_ADDR = $clog2(N2 * N_IN);
  localparam int LAT    = N2 + 2;
  localparam int H_MAX  = (1 << W_X) - 1;
  localparam int O_MAX  = (1 << (W_Y - 1)) - 1;
  localparam int O_MIN  = -(1 << (W_Y - 1));
  localparam int O_MASK = (1 << W_Y) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mlp_seq_if #(.N_IN(N_IN), .W_X(W_X), .W_K(W_K), .W_Y(W_Y), .W_ADDR(W_ADDR)) bus ();

  mlp_seq #(
    .N1(N1), .N2(N2), .W_X(W_X), .W_K(W_K), .W_Y(W_Y), .SHIFT1(SHIFT1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  int k1_m [N2*N_IN];
  int k2_m [N2];
  int v_mag [N_IN];
  bit v_pol [N_IN];
  int exp_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  function automatic int model_out();
    int acc = 0;
    int a;
    int h;
    for (int j = 0; j < N2; j++) begin
      a = 0;
      for (int i = 0; i < N_IN; i++)
        a += k1_m[j*N_IN + i] * (v_pol[i] ? v_mag[i] : -v_mag[i]);
      h = a >>> SHIFT1;
      if (h < 0)     h = 0;
      if (h > H_MAX) h = H_MAX;
      acc += k2_m[j] * h;
    end
`ifdef MLP_OUT_SAT_EN
    if (acc > O_MAX) acc = O_MAX;
    if (acc < O_MIN) acc = O_MIN;
`endif
    return acc & O_MASK;
  endfunction

  // Called at a negedge; leaves at the next negedge.
  task automatic wr(input logic sel, input int addr, input int data, input bit take);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = W_ADDR'(addr);
    bus.wr_data = W_K'(data);
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (take) begin
      if (sel == FC1_BANK) k1_m[addr] = data;
      else                 k2_m[addr] = data;
    end
  endtask

  task automatic load_all(input int k1v, input int k2v);
    for (int n = 0; n < N2*N_IN; n++) wr(FC1_BANK, n, k1v, 1'b1);
    for (int n = 0; n < N2; n++)      wr(FC2_BANK, n, k2v, 1'b1);
  endtask

  task automatic set_vec(input int mag, input bit pol);
    for (int i = 0; i < N_IN; i++) begin
      v_mag[i] = mag;
      v_pol[i] = pol;
    end
  endtask

  task automatic set_rand_vec();
    for (int i = 0; i < N_IN; i++) begin
      v_mag[i] = int'($urandom_range(0, H_MAX));
      v_pol[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Handshake one vector, optionally with a weight write in the same cycle.
  task automatic send(input bit do_wr, input logic sel, input int addr, input int data);
    int n = 0;
    while (bus.s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("s_ready_timeout", 32'(bus.s_ready), 1);
    for (int i = 0; i < N_IN; i++) begin
      bus.in_mag[i*W_X +: W_X] = W_X'(v_mag[i]);
      bus.in_pol[i]            = v_pol[i];
    end
    bus.s_valid = 1'b1;
    if (do_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = W_ADDR'(addr);
      bus.wr_data = W_K'(data);
      if (sel == FC1_BANK) k1_m[addr] = data;
      else                 k2_m[addr] = data;
    end
    exp_q.push_back(model_out());
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.wr_en   = 1'b0;
    chk("s_ready_busy", 32'(bus.s_ready), 0);
  endtask

  // Entered at the negedge of cycle 1 after the handshake. 'hold' cycles of
  // m_ready=0 are applied in DONE, with a (dropped) FC2 write in the first.
  task automatic get_result(input int hold);
    int n = 1;
    logic [31:0] e;
    while (bus.m_valid !== 1'b1 && n < 4*LAT) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, LAT);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q[0];
    chk("out", 32'(bus.out), e);
    chk("s_ready_done", 32'(bus.s_ready), 0);
    for (int c = 0; c < hold; c++) begin
      if (c == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = FC2_BANK;
        bus.wr_addr = '0;
        bus.wr_data = W_K'(-8);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      chk("bp_m_valid", 32'(bus.m_valid), 1);
      chk("bp_out", 32'(bus.out), e);
      chk("bp_s_ready", 32'(bus.s_ready), 0);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("m_valid_clear", 32'(bus.m_valid), 0);
    chk("s_ready_back", 32'(bus.s_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.in_mag  = '0;
    bus.in_pol  = '0;
    bus.m_ready = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    rstn        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_out", 32'(bus.out), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Weights cleared by reset: any input scores 0.
    set_rand_vec();
    send(1'b0, FC1_BANK, 0, 0);
    get_result(0);

    // k1=k2=+1, mag 1: a_j=49, h_j=3, out=30; then pol 0 -> ReLU -> 0.
    load_all(1, 1);
    set_vec(1, 1'b1);
    send(1'b0, FC1_BANK, 0, 0);
    get_result(0);
    set_vec(1, 1'b0);
    send(1'b0, FC1_BANK, 0, 0);
    get_result(0);

    // Backpressure in DONE; the k2[0] write there must be dropped.
    set_vec(1, 1'b1);
    send(1'b0, FC1_BANK, 0, 0);
    get_result(5);
    send(1'b0, FC1_BANK, 0, 0);
    get_result(0);

    // Write coincident with handshake applies to that vector: 9*3 - 8*3 = 3.
    send(1'b1, FC2_BANK, 3, -8);
    get_result(0);
    wr(FC2_BANK, 3, 1, 1'b1);

    // Large result: acc = 10*7*15 = 1050 -> 26 wrapped, 127 saturated.
    load_all(7, 7);
    set_vec(15, 1'b1);
    send(1'b0, FC1_BANK, 0, 0);
    get_result(0);

    // Random weights, out-of-range writes dropped, random vectors.
    for (int n = 0; n < N2*N_IN; n++) wr(FC1_BANK, n, int'($urandom_range(0, 15)) - 8, 1'b1);
    for (int n = 0; n < N2; n++)      wr(FC2_BANK, n, int'($urandom_range(0, 15)) - 8, 1'b1);
    wr(FC2_BANK, 19, 7, 1'b0);
    wr(FC1_BANK, N2*N_IN + 3, 7, 1'b0);
    for (int t = 0; t < 3; t++) begin
      set_rand_vec();
      send(1'b0, FC1_BANK, 0, 0);
      get_result(0);
    end
    set_rand_vec();
    send(1'b1, FC2_BANK, 5, int'($urandom_range(0, 15)) - 8);
    get_result(0);

    // Abort mid-FC1: outputs return to idle values and weights are cleared.
    load_all(1, 1);
    set_vec(1, 1'b1);
    send(1'b0, FC1_BANK, 0, 0);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_m_valid", 32'(bus.m_valid), 0);
    chk("abort_s_ready", 32'(bus.s_ready), 1);
    for (int n = 0; n < N2*N_IN; n++) k1_m[n] = 0;
    for (int n = 0; n < N2; n++)      k2_m[n] = 0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    set_vec(1, 1'b1);
    send(1'b0, FC1_BANK, 0, 0);
    get_result(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mlp_seq.md
Name: mlp_seq

Overview:
- Time-multiplexed successor to the combinational event-denoising MLP.
- Takes N1/2 magnitude/polarity channels, computes one FC1 hidden neuron per cycle (ReLU + requantise), accumulates FC2 in an overlapped pipeline stage, and emits a signed score.
- Weights live in a runtime-loadable register file, not constants.
- Valid/ready on both input and output, so it sits between the patch builder and the decision threshold stage.

Parameters:
- N1, 98, input taps; N_IN = N1/2 magnitude/polarity channels.
- N2, 10, hidden neurons.
- W_X, 4, unsigned magnitude width; also hidden activation width.
- W_K, 4, signed weight width.
- W_Y, 16, signed output width.
- SHIFT1, 4, arithmetic right shift applied to the FC1 sum before clipping.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  input vector valid.
- s_ready  out  1  block can accept a vector.
- in_mag  in  N_IN*W_X  per-channel magnitude.
- in_pol  in  N_IN  per-channel polarity: 1 = +mag, 0 = -mag.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- out  out  W_Y  signed score.
- wr_en  in  1  weight write strobe.
- wr_sel  in  1  0 = FC1 bank, 1 = FC2 bank.
- wr_addr  in  clog2(N2*N_IN)  FC1: j*N_IN+i; FC2: j.
- wr_data  in  W_K  signed weight.

Behaviour:
- Reset (asynchronous, rstn low):
  - state IDLE; s_ready=1, m_valid=0, out=0.
  - All weights and accumulators cleared to 0.
- Signed input: x_i = pol ? +mag : -mag, width W_X+1.
- FSM states IDLE -> FC1 -> DRAIN -> DONE -> IDLE.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready (cycle 0): latch in_mag/in_pol, clear the FC2 accumulator, set j=0, go to FC1.
- FC1 (cycles 1..N2):
  - Each cycle: a_j = sum_i k1[j][i]*x_i, width W_X+W_K+2+clog2(N_IN).
  - h_j = min(max(a_j>>>SHIFT1, 0), 2^W_X-1), registered.
  - j increments; after j=N2-1, go to DRAIN.
- FC2 accumulate:
  - Accumulates acc += k2[j_d]*h_j_d one cycle after each h_j is produced.
  - acc width W_X+W_K+2+clog2(N2), signed.
- DRAIN (cycle N2+1): last accumulation; go to DONE.
- DONE:
  - out = acc resized to W_Y (see optional feature) and m_valid=1 from cycle N2+2. Latency is N2+2 cycles from the input handshake.
  - out and m_valid stay stable until m_ready; on m_valid&&m_ready go to IDLE. s_ready rises the next cycle, so there is no same-cycle accept.
- s_ready=0 in every state except IDLE.
- Weight writes:
  - Accepted only in IDLE.
  - Writes in any other state, and out-of-range addresses (FC1 >= N2*N_IN, FC2 >= N2), are silently dropped.
  - A write in the same cycle as an input handshake takes effect; the new weight is used for that vector.
- s_valid held high in DONE has no effect until IDLE.
- rstn low mid-operation aborts immediately; the partial result is discarded and weights are cleared.

Optional Feature:
- Macro MLP_OUT_SAT_EN.
- Defined: out saturates acc to [-2^(W_Y-1), 2^(W_Y-1)-1].
- Undefined: out takes the low W_Y bits of acc (two's-complement wrap). This is the cheaper path, used when W_Y covers the full accumulator range.

Decomposition:
- Package mlp_pkg holds:
  - the width functions for the FC1 and FC2 sums;
  - state enum typedef (IDLE, FC1, DRAIN, DONE);
  - wr_sel encodings FC1_BANK=0, FC2_BANK=1.
- One natural sub-module, mlp_dot: combinational signed dot product of N_IN sign-magnitude inputs with one weight row, used for FC1.
- FSM, weight register file and FC2 accumulator stay in mlp_seq.

Test Plan:
- All weights 0 after reset; random input -> out=0, m_valid exactly 12 cycles after the handshake (N2=10).
- k1 all +1, k2 all +1, mag all 1, pol all 1 -> a_j=49, h_j=3, out=30.
- Same weights, pol all 0 -> a_j=-49, h_j=0 (ReLU), out=0.
- W_Y=8, k1 all +7, k2 all +7, mag 15, pol 1 -> h_j=15, acc=1050.
  - With MLP_OUT_SAT_EN: out=127.
  - Without MLP_OUT_SAT_EN: out=26.
- Backpressure: hold m_ready=0 for 5 cycles in DONE -> out and m_valid stable, s_ready=0. A weight write in this window is dropped; the next vector uses the old weights.
- Assert rstn low at FC1 cycle 5 -> m_valid=0, s_ready=1 after release, weights read 0; the next vector gives out=0.
